// File: rtl/shift_arbiter_seq_pkg.sv
// shift_arbiter_seq_pkg: shared types and constants for the serial shift arbiter.
//   - state encoding for the arbiter FSM
//   - requester ID constants
//   - default DATA_W / SHAMT_W / STEP
//   - latched per-operation control payload
// Optional feature macro used by the top: SHIFT_ARB_PERF_EN.
package shift_arbiter_seq_pkg;

  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned SHAMT_W_DEF = 5;
  localparam int unsigned STEP_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic REQ_ALU  = 1'b0;
  localparam logic REQ_ADDR = 1'b1;

  // Control bits captured with an accepted operation.
  typedef struct packed {
    logic left;
    logic logical;
    logic id;
  } op_ctl_t;

endpackage

// File: rtl/shift_arbiter_seq_if.sv
// shift_arbiter_seq_if: request/response bus of the serial shift arbiter.
//   master modport: requesters + result consumer (drive valids, operands, resp_ready)
//   slave  modport: the arbiter (drives readys and the response)
// Signals: req{0,1}_{valid,ready,data,shamt,left,logical}, resp_{valid,ready,data,id}.
interface shift_arbiter_seq_if
  import shift_arbiter_seq_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned SHAMT_W = SHAMT_W_DEF
);

  logic               req0_valid;
  logic               req0_ready;
  logic [DATA_W-1:0]  req0_data;
  logic [SHAMT_W-1:0] req0_shamt;
  logic               req0_left;
  logic               req0_logical;

  logic               req1_valid;
  logic               req1_ready;
  logic [DATA_W-1:0]  req1_data;
  logic [SHAMT_W-1:0] req1_shamt;
  logic               req1_left;
  logic               req1_logical;

  logic               resp_valid;
  logic               resp_ready;
  logic [DATA_W-1:0]  resp_data;
  logic               resp_id;

  modport master (
    output req0_valid, req0_data, req0_shamt, req0_left, req0_logical,
    output req1_valid, req1_data, req1_shamt, req1_left, req1_logical,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_data, resp_id
  );

  modport slave (
    input  req0_valid, req0_data, req0_shamt, req0_left, req0_logical,
    input  req1_valid, req1_data, req1_shamt, req1_left, req1_logical,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_data, resp_id
  );

endinterface

// File: rtl/shift_step_core.sv
// shift_step_core: one serial step of the shared shifter (combinational).
// Ports:
//   i_acc        current accumulator
//   i_k          bits to shift this step (0..STEP)
//   i_left       1 = left
//   i_logical    1 = logical, 0 = arithmetic
//   o_acc_nxt_c  accumulator after this step
// Arithmetic-left leaves the accumulator untouched; arithmetic-right steps
// compose exactly because each step refills with the current sign bit.
module shift_step_core #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned KW     = 4
) (
  input  logic [DATA_W-1:0] i_acc,
  input  logic [KW-1:0]     i_k,
  input  logic              i_left,
  input  logic              i_logical,
  output logic [DATA_W-1:0] o_acc_nxt_c
);

  // Per-step shift by direction/type
  always_comb begin
    o_acc_nxt_c = i_acc;
    if (i_logical) begin
      if (i_left) o_acc_nxt_c = i_acc << i_k;
      else        o_acc_nxt_c = i_acc >> i_k;
    end else if (!i_left) begin
      o_acc_nxt_c = DATA_W'($signed(i_acc) >>> i_k);
    end
  end

endmodule

// File: rtl/shift_arbiter_seq.sv
// shift_arbiter_seq: two-requester round-robin arbiter in front of a serial
// shifter that moves at most STEP bits per cycle.
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   bus          shift_arbiter_seq_if.slave (request ports, response port)
//   busy_cycles  [31:0] saturating count of non-IDLE cycles   (SHIFT_ARB_PERF_EN)
//   grants1      [15:0] wrapping count of requester-1 grants  (SHIFT_ARB_PERF_EN)
// Readys are combinational: only in IDLE, at most one, and low during reset.
// The round-robin pointer advances only when a response is consumed.
module shift_arbiter_seq
  import shift_arbiter_seq_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned SHAMT_W = SHAMT_W_DEF,
  parameter int unsigned STEP    = STEP_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  shift_arbiter_seq_if.slave       bus
`ifdef SHIFT_ARB_PERF_EN
  ,
  output logic [31:0]              busy_cycles,
  output logic [15:0]              grants1
`endif
);

  localparam int unsigned KW = $clog2(STEP) + 1;

  state_e             r_state;
  state_e             w_state_nxt;
  logic               r_rr_ptr;
  logic [DATA_W-1:0]  r_acc;
  logic [SHAMT_W-1:0] r_rem;
  op_ctl_t            r_ctl;
  logic               r_resp_valid;
  logic [DATA_W-1:0]  r_resp_data;
  logic               r_resp_id;

  logic               w_grant0;
  logic               w_grant1;
  logic               w_accept;
  logic [DATA_W-1:0]  w_in_data;
  logic [SHAMT_W-1:0] w_in_shamt;
  op_ctl_t            w_in_ctl;
  logic [KW-1:0]      w_k;
  logic [SHAMT_W-1:0] w_rem_nxt;
  logic [DATA_W-1:0]  w_acc_step;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = (w_in_shamt != '0) ? SHIFT : DONE;
      end
      SHIFT: begin
        if (w_rem_nxt == '0) w_state_nxt = DONE;
      end
      DONE: begin
        if (bus.resp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Grant outputs: single requester wins outright, contention goes to r_rr_ptr
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (r_state == IDLE && !rst) begin
      if (bus.req0_valid && (!bus.req1_valid || r_rr_ptr == REQ_ALU)) w_grant0 = 1'b1;
      else if (bus.req1_valid)                                        w_grant1 = 1'b1;
    end
  end

  assign w_accept       = w_grant0 | w_grant1;
  assign bus.req0_ready = w_grant0;
  assign bus.req1_ready = w_grant1;

  // Operand mux for the granted requester
  always_comb begin
    w_in_data        = bus.req0_data;
    w_in_shamt       = bus.req0_shamt;
    w_in_ctl.left    = bus.req0_left;
    w_in_ctl.logical = bus.req0_logical;
    w_in_ctl.id      = REQ_ALU;
    if (w_grant1) begin
      w_in_data        = bus.req1_data;
      w_in_shamt       = bus.req1_shamt;
      w_in_ctl.left    = bus.req1_left;
      w_in_ctl.logical = bus.req1_logical;
      w_in_ctl.id      = REQ_ADDR;
    end
  end

  // Step size k = min(rem, STEP); compared at 32 bits so STEP == DATA_W works
  always_comb begin
    w_k = KW'(STEP);
    if (32'(r_rem) < STEP) w_k = KW'(r_rem);
  end

  assign w_rem_nxt = r_rem - SHAMT_W'(w_k);

  shift_step_core #(
    .DATA_W (DATA_W),
    .KW     (KW)
  ) u_step (
    .i_acc       (w_acc_step_src()),
    .i_k         (w_k),
    .i_left      (r_ctl.left),
    .i_logical   (r_ctl.logical),
    .o_acc_nxt_c (w_acc_step)
  );

  function automatic logic [DATA_W-1:0] w_acc_step_src();
    return r_acc;
  endfunction

  // Datapath and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr     <= REQ_ALU;
      r_acc        <= '0;
      r_rem        <= '0;
      r_ctl        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_id    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_acc <= w_in_data;
            r_rem <= w_in_shamt;
            r_ctl <= w_in_ctl;
            // Zero shift goes straight to DONE with the operand as result
            if (w_in_shamt == '0) begin
              r_resp_valid <= 1'b1;
              r_resp_data  <= w_in_data;
              r_resp_id    <= w_in_ctl.id;
            end
          end
        end
        SHIFT: begin
          r_acc <= w_acc_step;
          r_rem <= w_rem_nxt;
          if (w_rem_nxt == '0) begin
            r_resp_valid <= 1'b1;
            r_resp_data  <= w_acc_step;
            r_resp_id    <= r_ctl.id;
          end
        end
        DONE: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_rr_ptr     <= ~r_ctl.id;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_data  = r_resp_data;
  assign bus.resp_id    = r_resp_id;

`ifdef SHIFT_ARB_PERF_EN
  logic [31:0] r_busy_cycles;
  logic [15:0] r_grants1;

  // Busy-cycle counter saturates; requester-1 grant counter wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy_cycles <= '0;
      r_grants1     <= '0;
    end else begin
      if (r_state != IDLE && r_busy_cycles != 32'hFFFF_FFFF)
        r_busy_cycles <= r_busy_cycles + 32'd1;
      if (w_grant1)
        r_grants1 <= r_grants1 + 16'd1;
    end
  end

  assign busy_cycles = r_busy_cycles;
  assign grants1     = r_grants1;
`endif

endmodule

// File: tb/tb_shift_arbiter_seq.sv
// tb_shift_arbiter_seq: self-checking bench for shift_arbiter_seq.
// A timeline model (in-flight op, due cycle, expected result from a single
// full-width shift, round-robin priority) is compared against the DUT on
// every cycle; directed cases pin latency and result literals.
// Works with or without SHIFT_ARB_PERF_EN.
module tb_shift_arbiter_seq;

  localparam int unsigned DW   = 32;
  localparam int unsigned SW   = 5;
  localparam int unsigned STEP = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shift_arbiter_seq_if #(.DATA_W(DW), .SHAMT_W(SW)) bus ();

`ifdef SHIFT_ARB_PERF_EN
  logic [31:0] busy_cycles;
  logic [15:0] grants1;
`endif

  shift_arbiter_seq #(.DATA_W(DW), .SHAMT_W(SW), .STEP(STEP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef SHIFT_ARB_PERF_EN
    ,
    .busy_cycles (busy_cycles),
    .grants1     (grants1)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model state
  bit          m_busy  = 1'b0;
  int          m_due   = 0;
  logic [31:0] m_data  = '0;
  logic        m_id    = 1'b0;
  logic        m_rr    = 1'b0;
  bit          prev_rst = 1'b0;
  int          n_resp  = 0;

  // Per-cycle observations
  bit          acc0, acc1;
  logic        s_rv;
  logic [31:0] s_rd;
  logic        s_rid;
  int          grant_log[$];

  function automatic logic [31:0] ref_shift(logic [31:0] d, int s, logic left, logic logical);
    if (logical) return left ? (d << s) : (d >> s);
    if (!left)   return 32'($signed(d) >>> s);
    return d;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s cyc=%0d timed out", nm, cyc);
  endtask

  // Compare DUT against the model for the current cycle, then advance the model
  task automatic check_cycle();
    logic e0, e1, erv;
    acc0  = 1'b0;
    acc1  = 1'b0;
    s_rv  = bus.resp_valid;
    s_rd  = bus.resp_data;
    s_rid = bus.resp_id;
    if (rst) begin
      chk("rst_ready0", 32'(bus.req0_ready), 32'd0);
      chk("rst_ready1", 32'(bus.req1_ready), 32'd0);
      if (prev_rst) begin
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_data",  bus.resp_data,       32'd0);
        chk("rst_resp_id",    32'(bus.resp_id),    32'd0);
      end
      m_busy   = 1'b0;
      m_rr     = 1'b0;
      prev_rst = 1'b1;
      return;
    end
    prev_rst = 1'b0;
    e0 = 1'b0;
    e1 = 1'b0;
    if (!m_busy) begin
      e0 = bus.req0_valid && (!bus.req1_valid || m_rr == 1'b0);
      e1 = bus.req1_valid && (!bus.req0_valid || m_rr == 1'b1);
    end
    chk("ready0", 32'(bus.req0_ready), 32'(e0));
    chk("ready1", 32'(bus.req1_ready), 32'(e1));
    erv = m_busy && (cyc >= m_due);
    chk("resp_valid", 32'(bus.resp_valid), 32'(erv));
    if (erv) begin
      chk("resp_data", bus.resp_data,    m_data);
      chk("resp_id",   32'(bus.resp_id), 32'(m_id));
    end
    if (erv && bus.resp_ready) begin
      m_busy = 1'b0;
      m_rr   = ~m_id;
      n_resp++;
    end else if (e0 || e1) begin
      m_busy = 1'b1;
      m_id   = e1;
      if (e1) begin
        m_data = ref_shift(bus.req1_data, int'(bus.req1_shamt), bus.req1_left, bus.req1_logical);
        m_due  = cyc + 1 + (int'(bus.req1_shamt) + int'(STEP) - 1) / int'(STEP);
        acc1   = 1'b1;
      end else begin
        m_data = ref_shift(bus.req0_data, int'(bus.req0_shamt), bus.req0_left, bus.req0_logical);
        m_due  = cyc + 1 + (int'(bus.req0_shamt) + int'(STEP) - 1) / int'(STEP);
        acc0   = 1'b1;
      end
      grant_log.push_back(int'(m_id));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int port, input logic [31:0] d, input int s, input logic l, input logic lg);
    if (port == 0) begin
      bus.req0_valid = 1'b1; bus.req0_data = d; bus.req0_shamt = SW'(s);
      bus.req0_left = l; bus.req0_logical = lg;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_data = d; bus.req1_shamt = SW'(s);
      bus.req1_left = l; bus.req1_logical = lg;
    end
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_shamt = '0;
    bus.req0_left = 1'b0;  bus.req0_logical = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_shamt = '0;
    bus.req1_left = 1'b0;  bus.req1_logical = 1'b0;
    bus.resp_ready = 1'b1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) tick();
    rst = 1'b0;
  endtask

  // One isolated operation with literal result, id and latency
  task automatic run_one(input int port, input logic [31:0] d, input int s, input logic l,
                         input logic lg, input logic [31:0] exp_d, input logic exp_id,
                         input int exp_lat);
    int t_acc, t_rv;
    logic [31:0] got_d;
    logic got_id;
    t_acc = -1; t_rv = -1; got_d = '0; got_id = 1'b0;
    set_req(port, d, s, l, lg);
    for (int i = 0; i < 20 && t_acc < 0; i++) begin
      tick();
      if (acc0 || acc1) t_acc = cyc - 1;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    if (t_acc < 0) begin
      fail_now("accept_wait");
      return;
    end
    for (int i = 0; i < 40 && t_rv < 0; i++) begin
      tick();
      if (s_rv) begin t_rv = cyc - 1; got_d = s_rd; got_id = s_rid; end
    end
    if (t_rv < 0) begin
      fail_now("resp_wait");
      return;
    end
    chk("lit_latency", 32'(t_rv - t_acc), 32'(exp_lat));
    chk("lit_data",    got_d,             exp_d);
    chk("lit_id",      32'(got_id),       32'(exp_id));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d simulation did not finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t_acc, t_rv, rv_cnt, resp_before;
    logic [31:0] bp_data;
    idle_inputs();
    do_reset(3);

    // Directed literal cases
    run_one(0, 32'h0000_0001, 20, 1'b1, 1'b1, 32'h0010_0000, 1'b0, 4);
    run_one(1, 32'h8000_0000, 31, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1, 5);
    run_one(0, 32'hDEAD_BEEF,  0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1);
    run_one(0, 32'hDEAD_BEEF, 12, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 3);
    run_one(1, 32'hF000_0000,  4, 1'b0, 1'b1, 32'h0F00_0000, 1'b1, 2);

    // Contention: both requesters continuously valid from reset
    do_reset(2);
    grant_log.delete();
    set_req(0, $urandom, int'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
    set_req(1, $urandom, int'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
    for (int i = 0; i < 80 && grant_log.size() < 4; i++) begin
      tick();
      if (acc0) set_req(0, $urandom, int'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
      if (acc1) set_req(1, $urandom, int'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
    end
    if (grant_log.size() < 4) fail_now("contention_grants");
    else begin
      chk("rr_grant0", 32'(grant_log[0]), 32'd0);
      chk("rr_grant1", 32'(grant_log[1]), 32'd1);
      chk("rr_grant2", 32'(grant_log[2]), 32'd0);
      chk("rr_grant3", 32'(grant_log[3]), 32'd1);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    for (int i = 0; i < 12; i++) tick();

    // Back-pressure: result held for 10 cycles while req1 waits
    bus.resp_ready = 1'b0;
    set_req(0, 32'h1234_5678, 9, 1'b0, 1'b1);
    t_acc = -1;
    for (int i = 0; i < 20 && t_acc < 0; i++) begin
      tick();
      if (acc0) t_acc = cyc - 1;
    end
    bus.req0_valid = 1'b0;
    set_req(1, 32'h0000_00FF, 3, 1'b1, 1'b1);
    t_rv = -1;
    for (int i = 0; i < 20 && t_rv < 0; i++) begin
      tick();
      if (s_rv) t_rv = cyc - 1;
    end
    if (t_acc < 0 || t_rv < 0) fail_now("backpressure_start");
    rv_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (s_rv) rv_cnt++;
    end
    chk("bp_held_cycles", 32'(rv_cnt), 32'd10);
    resp_before = n_resp;
    bus.resp_ready = 1'b1;
    tick();
    bp_data = s_rd;
    chk("bp_delivered", 32'(n_resp - resp_before), 32'd1);
    chk("bp_data", bp_data, 32'h0009_1A2B);
    for (int i = 0; i < 20 && bus.req1_valid; i++) begin
      tick();
      if (acc1) bus.req1_valid = 1'b0;
    end
    for (int i = 0; i < 8; i++) tick();

    // Reset during the second SHIFT cycle
    set_req(0, 32'hA5A5_0001, 31, 1'b1, 1'b1);
    t_acc = -1;
    for (int i = 0; i < 20 && t_acc < 0; i++) begin
      tick();
      if (acc0) t_acc = cyc - 1;
    end
    bus.req0_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rv_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (s_rv) rv_cnt++;
    end
    chk("rst_mid_no_resp", 32'(rv_cnt), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bus.resp_ready = ($urandom % 4) != 0;
      rst = ($urandom % 700) == 0;
      if (acc0) bus.req0_valid = 1'b0;
      if (acc1) bus.req1_valid = 1'b0;
      if (!bus.req0_valid && ($urandom % 2) == 0)
        set_req(0, $urandom, int'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
      if (!bus.req1_valid && ($urandom % 2) == 0)
        set_req(1, $urandom, int'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
      tick();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
